// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants for the multiplexed seven-segment scan driver
package sseg_pkg;
  localparam logic [6:0] SSEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam int NUM_DIGITS = 4;
  localparam int DP_BIT = 7;
endpackage

// File: rtl/sseg_scan_driver_if.sv
// sseg_scan_driver_if: digit patterns in, multiplexed anode/cathode bus out
interface sseg_scan_driver_if #(parameter int BW = 4);
  logic en;
  logic [BW-1:0] brightness;
  logic [6:0] in3, in2, in1, in0;
  logic [3:0] dp_n;
  logic [3:0] an;
  logic [7:0] sseg;
  logic frame_tick;
  modport master(output en, brightness, in3, in2, in1, in0, dp_n, input an, sseg, frame_tick);
  modport slave(input en, brightness, in3, in2, in1, in0, dp_n, output an, sseg, frame_tick);
endinterface

// File: rtl/scan_timer.sv
// scan_timer: free-running refresh counter with slot select, guard, pwm phase and frame reload strobe
module scan_timer #(
  parameter int N = 18,
  parameter int GUARD = 4,
  parameter int BW = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic [1:0] sel,
  output logic guard,
  output logic [BW-1:0] pwm,
  output logic load,
  output logic frame_tick
);
  logic [N-1:0] q;
  assign sel = q[N-1:N-2];
  assign guard = q[N-3:0] < (N-2)'(GUARD);
  assign pwm = q[BW-1:0];
  assign load = &q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
      frame_tick <= 1'b0;
    end else begin
      q <= q + 1'b1;
      frame_tick <= load;
    end
  end
endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: frame-synchronous shadowed digit scan with ghosting guard and PWM dimming
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N = 18,
  parameter int GUARD = 4,
  parameter int BW = 4
) (
  input logic clk,
  input logic reset_n,
  sseg_scan_driver_if.slave bus
);
  logic [1:0] sel;
  logic guard, load, lit;
  logic [BW-1:0] pwm;
  logic [6:0] shadow_in [NUM_DIGITS];
  logic [3:0] shadow_dp;
  scan_timer #(.N(N), .GUARD(GUARD), .BW(BW)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .sel(sel),
    .guard(guard),
    .pwm(pwm),
    .load(load),
    .frame_tick(bus.frame_tick)
  );
  assign lit = bus.en && !guard && (pwm <= bus.brightness);
  // shadow reloads only at frame wrap so a digit never changes mid-scan
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_in <= '{default: SSEG_BLANK};
      shadow_dp <= AN_OFF;
      bus.an <= AN_OFF;
      bus.sseg <= {1'b1, SSEG_BLANK};
    end else begin
      if (load) begin
        shadow_in <= '{bus.in0, bus.in1, bus.in2, bus.in3};
        shadow_dp <= bus.dp_n;
      end
      bus.an <= lit ? ~(4'b0001 << sel) : AN_OFF;
      bus.sseg[DP_BIT] <= lit ? shadow_dp[sel] : 1'b1;
      bus.sseg[DP_BIT-1:0] <= lit ? shadow_in[sel] : SSEG_BLANK;
    end
  end
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: directed checks of scan order, guard, dimming, frame capture, enable and reset
module tb_sseg_scan_driver;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int qm = 0;
  logic [6:0] pat [4];
  logic [3:0] dpn;
  logic [3:0] an_tab [4];
  sseg_scan_driver_if #(.BW(2)) bus();
  sseg_scan_driver #(.N(6), .GUARD(2), .BW(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    qm = reset_n ? (qm + 1) % 64 : 0;
  endtask

  task automatic apply;
    bus.in0 = pat[0];
    bus.in1 = pat[1];
    bus.in2 = pat[2];
    bus.in3 = pat[3];
    bus.dp_n = dpn;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    while (bus.frame_tick !== 1'b1 && n < 70) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    bus.en = 1'b1;
    bus.brightness = 2'd3;
    pat[0] = 7'b1000000;
    pat[1] = 7'b1111001;
    pat[2] = 7'b0100100;
    pat[3] = 7'b0110000;
    dpn = 4'b1110;
    apply;
    reset_n = 1'b0;
    repeat (5) begin
      tick;
      checks++;
      if (bus.an !== 4'b1111 || bus.sseg !== 8'hFF || bus.frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold an=%b sseg=%h ft=%b want an=1111 sseg=ff ft=0", bus.an, bus.sseg, bus.frame_tick);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (bus.an !== 4'b1111 || bus.sseg !== 8'hFF || bus.frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_guard cycle %0d an=%b sseg=%h ft=%b want an=1111 sseg=ff ft=0", i, bus.an, bus.sseg, bus.frame_tick);
      end
    end
    tick;
    checks++;
    if (bus.an !== 4'b1110 || bus.sseg !== 8'hFF) begin
      errors++;
      $display("FAIL reset_blank_shadow an=%b sseg=%h want an=1110 sseg=ff", bus.an, bus.sseg);
    end
  endtask

  task automatic test_full;
    int n, s, off;
    int cnt [4];
    logic [3:0] ea;
    logic [7:0] es;
    cnt = '{0, 0, 0, 0};
    wait_frame(n);
    checks++;
    if (bus.frame_tick !== 1'b1 || qm != 0) begin
      errors++;
      $display("FAIL full_frame_sync ft=%b q=%0d after %0d cycles want ft=1 q=0", bus.frame_tick, qm, n);
    end
    for (int i = 0; i < 64; i++) begin
      tick;
      s = i / 16;
      off = i % 16;
      ea = off >= 2 ? an_tab[s] : 4'b1111;
      es = off >= 2 ? {dpn[s], pat[s]} : 8'hFF;
      checks++;
      if (bus.an !== ea || bus.sseg !== es) begin
        errors++;
        $display("FAIL full_scan q=%0d an=%b sseg=%b want an=%b sseg=%b", i, bus.an, bus.sseg, ea, es);
      end
      if (bus.an === an_tab[s]) cnt[s]++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt[k] != 14) begin
        errors++;
        $display("FAIL full_slot_count slot %0d lit %0d want 14", k, cnt[k]);
      end
    end
  endtask

  task automatic test_dim;
    int s, off;
    int cnt [4];
    logic lit;
    logic [3:0] ea;
    logic [7:0] es;
    cnt = '{0, 0, 0, 0};
    bus.brightness = 2'd0;
    for (int i = 0; i < 64; i++) begin
      tick;
      s = i / 16;
      off = i % 16;
      lit = off == 4 || off == 8 || off == 12;
      ea = lit ? an_tab[s] : 4'b1111;
      es = lit ? {dpn[s], pat[s]} : 8'hFF;
      checks++;
      if (bus.an !== ea || bus.sseg !== es) begin
        errors++;
        $display("FAIL dim_scan q=%0d an=%b sseg=%b want an=%b sseg=%b", i, bus.an, bus.sseg, ea, es);
      end
      if (bus.an !== 4'b1111) cnt[s]++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt[k] != 3) begin
        errors++;
        $display("FAIL dim_slot_count slot %0d lit %0d want 3", k, cnt[k]);
      end
    end
    bus.brightness = 2'd3;
  endtask

  task automatic test_tearing;
    logic [6:0] old;
    int ft;
    old = pat[2];
    while (qm != 20) tick;
    pat[2] = 7'b0000000;
    apply;
    ft = 0;
    for (int i = 20; i < 64; i++) begin
      tick;
      if (bus.frame_tick === 1'b1) ft++;
      checks++;
      if (i >= 34 && i < 48 && bus.sseg !== {1'b1, old}) begin
        errors++;
        $display("FAIL tear_old q=%0d sseg=%b want %b", i, bus.sseg, {1'b1, old});
      end
    end
    checks++;
    if (ft != 1 || bus.frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL tear_tick_first pulses %0d ft_now=%b want 1 pulse ending at wrap", ft, bus.frame_tick);
    end
    ft = 0;
    for (int i = 0; i < 64; i++) begin
      tick;
      if (bus.frame_tick === 1'b1) ft++;
      checks++;
      if (i >= 34 && i < 48 && bus.sseg !== {1'b1, pat[2]}) begin
        errors++;
        $display("FAIL tear_new q=%0d sseg=%b want %b", i, bus.sseg, {1'b1, pat[2]});
      end
    end
    checks++;
    if (ft != 1 || bus.frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL tear_tick_period pulses %0d ft_now=%b want 1 pulse per 64 cycles", ft, bus.frame_tick);
    end
  endtask

  task automatic test_enable;
    int n;
    while (qm != 35) tick;
    bus.en = 1'b0;
    for (int i = 35; i < 40; i++) begin
      tick;
      checks++;
      if (bus.an !== 4'b1111 || bus.sseg !== 8'hFF) begin
        errors++;
        $display("FAIL en_off q=%0d an=%b sseg=%h want an=1111 sseg=ff", i, bus.an, bus.sseg);
      end
    end
    bus.en = 1'b1;
    tick;
    checks++;
    if (bus.an !== 4'b1011 || bus.sseg !== 8'h80) begin
      errors++;
      $display("FAIL en_resume an=%b sseg=%h want an=1011 sseg=80", bus.an, bus.sseg);
    end
    wait_frame(n);
    checks++;
    if (n != 23) begin
      errors++;
      $display("FAIL en_no_restart next tick after %0d cycles want 23", n);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    while (qm != 40) tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    checks++;
    if (bus.an !== 4'b1111 || bus.sseg !== 8'hFF || bus.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset an=%b sseg=%h ft=%b want an=1111 sseg=ff ft=0", bus.an, bus.sseg, bus.frame_tick);
    end
    n = 0;
    while (bus.frame_tick !== 1'b1 && n < 70) begin
      tick;
      n++;
      checks++;
      if (bus.sseg !== 8'hFF) begin
        errors++;
        $display("FAIL mid_reset_blank cycle %0d sseg=%h want ff", n, bus.sseg);
      end
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL mid_reset_tick first tick after %0d cycles want 64", n);
    end
    repeat (3) tick;
    checks++;
    if (bus.an !== 4'b1110 || bus.sseg !== 8'b01000000) begin
      errors++;
      $display("FAIL mid_reset_reload an=%b sseg=%b want an=1110 sseg=01000000", bus.an, bus.sseg);
    end
  endtask

  initial begin
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    test_reset;
    test_full;
    test_dim;
    test_tearing;
    test_enable;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Consumes the four per-digit active-low 7-segment patterns that our display test tops produce (blank = 7'b1111111).
- Drives them onto a shared, time-multiplexed cathode bus with active-low digit enables, for boards with a common segment bus instead of four dedicated digit outputs.
- Adds frame-synchronous pattern capture (no tearing), an inter-digit ghosting guard, and PWM brightness control.
- Sits between the bin_to_sseg decoders and the board pins.

Parameters:
- N, 18: refresh counter width; frame = 2^N cycles, slot per digit = 2^(N-2) cycles.
- GUARD, 4: blank cycles at the start of each slot; must be < 2^(N-2).
- BW, 4: brightness/PWM width; must be <= N-2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- en  in  1  1 = display enabled; 0 = all digits dark
- brightness  in  BW  PWM duty select
- in3, in2, in1, in0  in  7 each  active-low segment patterns for digits 3..0 (bit 6 = g ... bit 0 = a)
- dp_n  in  4  active-low decimal points; bit k belongs to digit k
- an  out  4  active-low digit enables; an[k] selects digit k
- sseg  out  8  active-low bus; sseg[7] = dp, sseg[6:0] = segments
- frame_tick  out  1  one-cycle pulse when shadow patterns reload

Behaviour:
- Reset, while reset_n=0 at a clk edge:
  - q <= 0; shadow patterns <= 7'h7F; shadow dp <= 4'hF.
  - an <= 4'b1111; sseg <= 8'hFF; frame_tick <= 0.
  - Asserting reset mid-frame does the same: outputs are dark after the next edge and the scan restarts at digit 0.
- Counter q[N-1:0] increments every cycle and wraps 2^N-1 -> 0.
- Derived signals:
  - sel = q[N-1:N-2]
  - off = q[N-3:0]
  - pwm = q[BW-1:0]
  - guard = (off < GUARD)
  - lit = en && !guard && (pwm <= brightness)
- Shadow load: on the edge where q == 2^N-1, shadow <= {in3..in0, dp_n} and frame_tick <= 1. On every other edge, frame_tick <= 0.
  - The pulse is therefore visible in the cycle where q == 0.
  - Input changes at any other time are not shown until the next frame.
- Output register, every edge:
  - If lit: an <= ~(4'b0001 << sel); sseg <= {shadow_dp[sel], shadow_in[sel]}.
  - Otherwise: an <= 4'b1111; sseg <= 8'hFF.
  - Latency is one cycle: outputs during cycle t reflect q(t-1).
- At most one an bit is low in any cycle. an is never low while sseg carries another digit's data.
- brightness = all-ones gives full on (every non-guard cycle). brightness = 0 gives a 1/2^BW duty.
- At a slot boundary, guard forces at least GUARD dark cycles between digits. This holds even when brightness = max.
- en deasserted blanks from the next edge; the counter and shadow registers keep running.
- Register-only outputs; no combinational path from inputs to outputs.

Decomposition:
- Package sseg_pkg: SSEG_BLANK = 7'b1111111, AN_OFF = 4'b1111, NUM_DIGITS = 4, and the 8-bit bus layout constants (DP_BIT = 7).
- One sub-module, scan_timer:
  - Owns q and frame_tick.
  - Outputs sel, guard, pwm and load (q == 2^N-1).
- The top holds the shadow registers, the lit logic and the output mux/registers.

Test Plan (N=6, GUARD=2, BW=2; slot = 16, frame = 64 cycles):
- Reset held 5 cycles, then released -> an=4'b1111, sseg=8'hFF, frame_tick=0 during reset and on the first edge after release. Dark for the first 2 output cycles of slot 0 (guard), then continues normally.
- en=1, brightness=3, in0=7'b1000000, dp_n=4'b1110, in1..in3 distinct; wait one frame -> slot 0 shows an=4'b1110, sseg=8'b01000000 for 14 of 16 cycles (offsets 2..15, one cycle late). Slots 1..3 show the matching an/in patterns.
- brightness=0 -> per slot, only offsets 4, 8, 12 are lit (3 cycles); all other cycles are an=4'b1111, sseg=8'hFF.
- Change in2 at q=20 (mid-frame) -> slot 2 of that frame still shows the old value. frame_tick pulses exactly once every 64 cycles. The new value appears in the next frame's slot 2.
- en=0 at q=35 -> an=4'b1111, sseg=8'hFF from the next cycle. Re-enable resumes at the current q position with no restart.
- reset_n=0 for one edge at q=40 -> next cycle an=4'b1111, sseg=8'hFF, shadow blank. The next frame_tick arrives 64 cycles after release, and the display stays blank until then.
